// File: rtl/xeng_bl_order_sched.sv
// ---------------------------------------------------------------------------
// xeng_bl_order_sched
// Baseline-order scheduler for the X-engine correlator. Walks antenna pairs
// (ant_a, ant_b) in lower-triangular order (a ascending, b ascending up to a
// or a-1). It marks the first and last baseline of each pass, counts passes
// per accumulation, and flips the double-buffer select between accumulations.
// ---------------------------------------------------------------------------
module xeng_bl_order_sched #(
    parameter int N_ANTS        = 8,
    parameter int ANT_BITS      = 3,
    parameter int INCLUDE_AUTOS = 1,
    parameter int ACC_LEN       = 4,
    parameter int BL_BITS       = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync,
    input  logic                en,
    output logic [ANT_BITS-1:0] ant_a,
    output logic [ANT_BITS-1:0] ant_b,
    output logic [BL_BITS-1:0]  bl_idx,
    output logic                valid,
    output logic                first,
    output logic                last,
    output logic                acc_done,
    output logic                buf_sel
);

    localparam int N_BLS     = (INCLUDE_AUTOS != 0) ? (N_ANTS * (N_ANTS + 1)) / 2
                                                    : (N_ANTS * (N_ANTS - 1)) / 2;
    localparam int PASS_BITS = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    // Pair enumeration starts at a=0 with autos and at a=1 without.
    localparam logic [ANT_BITS-1:0]  A_FIRST   = ANT_BITS'((INCLUDE_AUTOS != 0) ? 0 : 1);
    localparam logic [ANT_BITS-1:0]  A_LAST    = ANT_BITS'(N_ANTS - 1);
    localparam logic [BL_BITS-1:0]   BL_LAST   = BL_BITS'(N_BLS - 1);
    localparam logic [PASS_BITS-1:0] PASS_LAST = PASS_BITS'(ACC_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_r;

    // Pointer to the pair that will be emitted on the next enabled cycle.
    logic [ANT_BITS-1:0]   ptr_a_r;
    logic [ANT_BITS-1:0]   ptr_b_r;
    logic [BL_BITS-1:0]    ptr_bl_r;
    logic [PASS_BITS-1:0]  pass_cnt_r;

    logic [ANT_BITS-1:0]   ant_a_r;
    logic [ANT_BITS-1:0]   ant_b_r;
    logic [BL_BITS-1:0]    bl_idx_r;
    logic                  valid_r;
    logic                  first_r;
    logic                  last_r;
    logic                  acc_done_r;
    logic                  buf_sel_r;

    logic [ANT_BITS-1:0]   b_lim_s;
    logic [ANT_BITS-1:0]   nxt_a_s;
    logic [ANT_BITS-1:0]   nxt_b_s;
    logic [BL_BITS-1:0]    nxt_bl_s;
    logic [PASS_BITS-1:0]  nxt_pass_s;
    logic                  is_last_s;
    logic                  is_acc_end_s;

    // Largest legal b for a given a: a itself with autos, a-1 without.
    function automatic logic [ANT_BITS-1:0] b_limit(input logic [ANT_BITS-1:0] a);
        logic [ANT_BITS-1:0] lim;
        if (INCLUDE_AUTOS != 0) begin
            lim = a;
        end else begin
            lim = a - ANT_BITS'(1'b1);
        end
        return lim;
    endfunction

    // Successor of the current pointer in triangular order, with pass wrap.
    always_comb begin
        b_lim_s      = b_limit(ptr_a_r);
        nxt_a_s      = ptr_a_r;
        nxt_b_s      = ptr_b_r;
        nxt_bl_s     = ptr_bl_r;
        nxt_pass_s   = pass_cnt_r;
        is_last_s    = (ptr_bl_r == BL_LAST);
        is_acc_end_s = is_last_s && (pass_cnt_r == PASS_LAST);

        if (ptr_b_r == b_lim_s) begin
            if (ptr_a_r == A_LAST) begin
                nxt_a_s = A_FIRST;
                nxt_b_s = {ANT_BITS{1'b0}};
            end else begin
                nxt_a_s = ptr_a_r + ANT_BITS'(1'b1);
                nxt_b_s = {ANT_BITS{1'b0}};
            end
        end else begin
            nxt_a_s = ptr_a_r;
            nxt_b_s = ptr_b_r + ANT_BITS'(1'b1);
        end

        if (is_last_s) begin
            nxt_bl_s = {BL_BITS{1'b0}};
            if (is_acc_end_s) begin
                nxt_pass_s = {PASS_BITS{1'b0}};
            end else begin
                nxt_pass_s = pass_cnt_r + PASS_BITS'(1'b1);
            end
        end else begin
            nxt_bl_s   = ptr_bl_r + BL_BITS'(1'b1);
            nxt_pass_s = pass_cnt_r;
        end
    end

    // Control FSM, pointer advance and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_a_r    <= {ANT_BITS{1'b0}};
            ptr_b_r    <= {ANT_BITS{1'b0}};
            ptr_bl_r   <= {BL_BITS{1'b0}};
            pass_cnt_r <= {PASS_BITS{1'b0}};
            ant_a_r    <= {ANT_BITS{1'b0}};
            ant_b_r    <= {ANT_BITS{1'b0}};
            bl_idx_r   <= {BL_BITS{1'b0}};
            valid_r    <= 1'b0;
            first_r    <= 1'b0;
            last_r     <= 1'b0;
            acc_done_r <= 1'b0;
            buf_sel_r  <= 1'b0;
        end else if (sync) begin
            // Restart has priority over en: realign order and accumulation.
            state_r    <= ST_RUN;
            ptr_a_r    <= A_FIRST;
            ptr_b_r    <= {ANT_BITS{1'b0}};
            ptr_bl_r   <= {BL_BITS{1'b0}};
            pass_cnt_r <= {PASS_BITS{1'b0}};
            buf_sel_r  <= 1'b0;
            valid_r    <= 1'b0;
            first_r    <= 1'b0;
            last_r     <= 1'b0;
            acc_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_IDLE;
                    valid_r    <= 1'b0;
                    first_r    <= 1'b0;
                    last_r     <= 1'b0;
                    acc_done_r <= 1'b0;
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                    // The buffer flips right after the accumulation's final
                    // baseline has been presented, so the whole accumulation
                    // (including its acc_done beat) sees one buf_sel value.
                    if (acc_done_r) begin
                        buf_sel_r <= ~buf_sel_r;
                    end else begin
                        buf_sel_r <= buf_sel_r;
                    end
                    if (en) begin
                        ant_a_r    <= ptr_a_r;
                        ant_b_r    <= ptr_b_r;
                        bl_idx_r   <= ptr_bl_r;
                        valid_r    <= 1'b1;
                        first_r    <= (ptr_bl_r == {BL_BITS{1'b0}});
                        last_r     <= is_last_s;
                        acc_done_r <= is_acc_end_s;
                        ptr_a_r    <= nxt_a_s;
                        ptr_b_r    <= nxt_b_s;
                        ptr_bl_r   <= nxt_bl_s;
                        pass_cnt_r <= nxt_pass_s;
                    end else begin
                        // Pair outputs and pointers hold so the order resumes cleanly.
                        valid_r    <= 1'b0;
                        first_r    <= 1'b0;
                        last_r     <= 1'b0;
                        acc_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    valid_r    <= 1'b0;
                    first_r    <= 1'b0;
                    last_r     <= 1'b0;
                    acc_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign ant_a    = ant_a_r;
    assign ant_b    = ant_b_r;
    assign bl_idx   = bl_idx_r;
    assign valid    = valid_r;
    assign first    = first_r;
    assign last     = last_r;
    assign acc_done = acc_done_r;
    assign buf_sel  = buf_sel_r;

endmodule

// File: tb/tb_xeng_bl_order_sched.sv
// ---------------------------------------------------------------------------
// Directed bench for xeng_bl_order_sched: two instances with N_ANTS=4,
// one with autos and ACC_LEN=2, one without autos and ACC_LEN=1.
// ---------------------------------------------------------------------------
module tb_xeng_bl_order_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync;
    logic       en;

    logic [1:0] a0, b0;
    logic [3:0] bl0;
    logic       v0, f0, l0, ad0, bs0;
    logic [1:0] a1, b1;
    logic [2:0] bl1;
    logic       v1, f1, l1, ad1, bs1;

    int checks   = 0;
    int failures = 0;

    int ea0 [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    int eb0 [10] = '{0, 0, 1, 0, 1, 2, 0, 1, 2, 3};
    int ea1 [6]  = '{1, 2, 2, 3, 3, 3};
    int eb1 [6]  = '{0, 0, 1, 0, 1, 2};

    xeng_bl_order_sched #(
        .N_ANTS(4), .ANT_BITS(2), .INCLUDE_AUTOS(1), .ACC_LEN(2), .BL_BITS(4)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .sync(sync), .en(en),
        .ant_a(a0), .ant_b(b0), .bl_idx(bl0), .valid(v0),
        .first(f0), .last(l0), .acc_done(ad0), .buf_sel(bs0)
    );

    xeng_bl_order_sched #(
        .N_ANTS(4), .ANT_BITS(2), .INCLUDE_AUTOS(0), .ACC_LEN(1), .BL_BITS(3)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .sync(sync), .en(en),
        .ant_a(a1), .ant_b(b1), .bl_idx(bl1), .valid(v1),
        .first(f1), .last(l1), .acc_done(ad1), .buf_sel(bs1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // u0 (autos, ACC_LEN=2): k = index in pass, g = valid count since sync.
    task automatic chk0(input int k, input int g);
        chk("u0_valid", 32'(v0), 32'd1);
        chk("u0_ant_a", 32'(a0), 32'(ea0[k]));
        chk("u0_ant_b", 32'(b0), 32'(eb0[k]));
        chk("u0_bl_idx", 32'(bl0), 32'(k));
        chk("u0_first", 32'(f0), 32'(k == 0));
        chk("u0_last", 32'(l0), 32'(k == 9));
        chk("u0_acc_done", 32'(ad0), 32'((g % 20) == 19));
        chk("u0_buf_sel", 32'(bs0), 32'((g / 20) % 2));
    endtask

    // u1 (no autos, ACC_LEN=1): acc_done on every last, buf_sel flips each pass.
    task automatic chk1(input int k, input int g);
        chk("u1_valid", 32'(v1), 32'd1);
        chk("u1_ant_a", 32'(a1), 32'(ea1[k]));
        chk("u1_ant_b", 32'(b1), 32'(eb1[k]));
        chk("u1_no_auto", 32'(a1 == b1), 32'd0);
        chk("u1_bl_idx", 32'(bl1), 32'(k));
        chk("u1_first", 32'(f1), 32'(k == 0));
        chk("u1_last", 32'(l1), 32'(k == 5));
        chk("u1_acc_done", 32'(ad1), 32'(k == 5));
        chk("u1_buf_sel", 32'(bs1), 32'((g / 6) % 2));
    endtask

    initial begin
        rst_n = 1'b0;
        sync  = 1'b0;
        en    = 1'b0;
        #12;
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_ant_a", 32'(a0), 32'd0);
        chk("rst_bl_idx", 32'(bl0), 32'd0);
        chk("rst_buf_sel", 32'(bs0), 32'd0);
        tick();
        rst_n = 1'b1;

        // IDLE: en alone produces nothing until sync.
        en = 1'b1;
        tick();
        tick();
        chk("idle_valid0", 32'(v0), 32'd0);
        chk("idle_valid1", 32'(v1), 32'd0);

        // sync with en=1: that cycle stays invalid.
        sync = 1'b1;
        tick();
        chk("sync_valid0", 32'(v0), 32'd0);
        chk("sync_valid1", 32'(v1), 32'd0);
        sync = 1'b0;

        // Continuous run: orders, wrap, accumulation and buffer flips.
        for (int g = 0; g < 42; g++) begin
            tick();
            chk0(g % 10, g);
            chk1(g % 6, g);
        end

        // en gap from pair (1,0): outputs hold, order resumes at (1,1).
        en = 1'b0;
        tick();
        chk("gap_valid", 32'(v0), 32'd0);
        chk("gap_ant_a", 32'(a0), 32'd1);
        chk("gap_ant_b", 32'(b0), 32'd0);
        chk("gap_bl_idx", 32'(bl0), 32'd1);
        chk("gap_first", 32'(f0), 32'd0);
        chk("gap_valid1", 32'(v1), 32'd0);
        chk("gap_ant_a1", 32'(a1), 32'd3);
        chk("gap_ant_b1", 32'(b1), 32'd2);
        chk("gap_bl_idx1", 32'(bl1), 32'd5);
        tick();
        chk("gap2_valid", 32'(v0), 32'd0);
        chk("gap2_ant_a", 32'(a0), 32'd1);
        en = 1'b1;
        tick();
        chk0(2, 42);
        chk("resume_ant_a1", 32'(a1), 32'd1);
        chk("resume_ant_b1", 32'(b1), 32'd0);
        chk("resume_first1", 32'(f1), 32'd1);

        // Run to pair (2,1) in a pass where buf_sel is 1.
        for (int g = 43; g < 65; g++) begin
            tick();
            chk0(g % 10, g);
        end

        // sync mid-pass with en=1.
        sync = 1'b1;
        tick();
        chk("midsync_valid", 32'(v0), 32'd0);
        chk("midsync_buf_sel", 32'(bs0), 32'd0);
        sync = 1'b0;
        for (int g = 0; g < 23; g++) begin
            tick();
            chk0(g % 10, g);
        end

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(v0), 32'd0);
        chk("arst_ant_a", 32'(a0), 32'd0);
        chk("arst_ant_b", 32'(b0), 32'd0);
        chk("arst_bl_idx", 32'(bl0), 32'd0);
        chk("arst_buf_sel", 32'(bs0), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", 32'(v0), 32'd0);
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        chk0(0, 0);
        tick();
        chk0(1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
